arm_multicycle_ctrl: RTL and testbench

- Main control FSM that sequences the multicycle version of the ARM datapath: fetch, decode, memory, execute, writeback and branch.
- Drives the raw PCS/RegW/MemW/FlagW/NoWrite requests consumed by the condition-check/flag logic, plus the datapath mux selects.
- Adds a ready handshake with unified instruction/data memory and a stall watchdog.

---
 rtl/arm_multicycle_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_arm_multicycle_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/arm_multicycle_ctrl.sv
// Main control FSM for the multicycle ARM datapath with a memory-ready
// handshake and a stall watchdog on the memory wait states.
module arm_multicycle_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       mem_ready,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUCtrl,
  output logic       RegW,
  output logic       MemW,
  output logic       PCS,
  output logic [1:0] FlagW,
  output logic       NoWrite,
  output logic       illegal_op,
  output logic       mem_err,
  output logic [3:0] state_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXECR  = 4'd6;
  localparam logic [3:0] EXECI  = 4'd7;
  localparam logic [3:0] ALUWB  = 4'd8;
  localparam logic [3:0] BRANCH = 4'd9;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  logic [3:0]       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             wait_st, expire;
  logic [1:0]       dp_alu;
  logic [1:0]       dp_flagw;

  function automatic logic [1:0] alu_dec(input logic [3:0] cmd);
    case (cmd)
      4'b0100: alu_dec = ALU_ADD;
      4'b0010: alu_dec = ALU_SUB;
      4'b1010: alu_dec = ALU_SUB;
      4'b0000: alu_dec = ALU_AND;
      4'b1100: alu_dec = ALU_ORR;
      default: alu_dec = ALU_ADD;
    endcase
  endfunction

  // Logical ops only update N/Z; arithmetic ops update all four flags.
  function automatic logic [1:0] flagw_dec(input logic s, input logic [1:0] alu);
    if (!s)
      flagw_dec = 2'b00;
    else if (alu[1])
      flagw_dec = 2'b10;
    else
      flagw_dec = 2'b11;
  endfunction

  always_comb begin
    wait_st  = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
    expire   = wait_st && !mem_ready && (cnt == CNT_W'(TIMEOUT - 1));
    dp_alu   = alu_dec(Funct[4:1]);
    dp_flagw = flagw_dec(Funct[0], dp_alu);
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = FETCH;
    cnt_nx   = '0;
    case (state)
      FETCH:  state_nx = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (Op)
          2'b01:   state_nx = MEMADR;
          2'b00:   state_nx = Funct[5] ? EXECI : EXECR;
          2'b10:   state_nx = BRANCH;
          default: state_nx = FETCH;
        endcase
      end
      MEMADR: state_nx = Funct[0] ? MEMRD : MEMWR;
      MEMRD:  state_nx = mem_ready ? MEMWB : MEMRD;
      MEMWB:  state_nx = FETCH;
      MEMWR:  state_nx = mem_ready ? FETCH : MEMWR;
      EXECR:  state_nx = ALUWB;
      EXECI:  state_nx = ALUWB;
      ALUWB:  state_nx = FETCH;
      BRANCH: state_nx = FETCH;
      default: state_nx = FETCH;
    endcase
    // Watchdog expiry aborts the access; FETCH re-enters itself with a fresh count.
    if (expire)
      state_nx = FETCH;
    if (wait_st && !mem_ready && !expire && (state_nx == state))
      cnt_nx = (cnt == CNT_W'(TIMEOUT)) ? cnt : cnt + CNT_W'(1);
  end

  always_comb begin
    IRWrite    = 1'b0;
    NextPC     = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUCtrl    = ALU_ADD;
    RegW       = 1'b0;
    MemW       = 1'b0;
    PCS        = 1'b0;
    FlagW      = 2'b00;
    NoWrite    = 1'b0;
    illegal_op = 1'b0;
    mem_err    = 1'b0;
    state_o    = 4'd0;
    if (reset) begin
      state_o = state;
      mem_err = expire;
      case (state)
        FETCH: begin
          IRWrite   = mem_ready;
          NextPC    = mem_ready;
          ALUSrcA   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
        end
        DECODE: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b10;
          ResultSrc  = 2'b10;
          illegal_op = (Op == 2'b11);
        end
        MEMADR: ALUSrcB = 2'b01;
        MEMRD:  AdrSrc = 1'b1;
        MEMWB: begin
          ResultSrc = 2'b01;
          RegW      = 1'b1;
        end
        MEMWR: begin
          AdrSrc = 1'b1;
          MemW   = 1'b1;
        end
        EXECR: begin
          ALUCtrl = dp_alu;
          FlagW   = dp_flagw;
        end
        EXECI: begin
          ALUSrcB = 2'b01;
          ALUCtrl = dp_alu;
          FlagW   = dp_flagw;
        end
        ALUWB: begin
          RegW    = 1'b1;
          NoWrite = (Funct[4:1] == 4'b1010);
        end
        BRANCH: begin
          ALUSrcB   = 2'b01;
          ResultSrc = 2'b10;
          PCS       = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Directed bench for arm_multicycle_ctrl: instruction sequences, watchdog
// boundaries and asynchronous reset during a store.
module tb_arm_multicycle_ctrl;

  logic       CLK = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       mem_ready;
  logic       IRWrite, NextPC, AdrSrc, ALUSrcA, RegW, MemW, PCS, NoWrite;
  logic       illegal_op, mem_err;
  logic [1:0] ResultSrc, ALUSrcB, ALUCtrl, FlagW;
  logic [3:0] state_o;

  int ncmp  = 0;
  int nfail = 0;

  arm_multicycle_ctrl #(.TIMEOUT(16)) dut (
    .CLK(CLK), .reset(reset), .Op(Op), .Funct(Funct), .mem_ready(mem_ready),
    .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUCtrl(ALUCtrl), .RegW(RegW),
    .MemW(MemW), .PCS(PCS), .FlagW(FlagW), .NoWrite(NoWrite),
    .illegal_op(illegal_op), .mem_err(mem_err), .state_o(state_o)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Data-processing instruction from FETCH (mem_ready=1) back to FETCH.
  task automatic dp_instr(input string tag, input logic [5:0] f, input logic [3:0] exs,
                          input logic [1:0] alu, input logic [1:0] fw, input logic nw);
    Op = 2'b00; Funct = f;
    tick(); settle();
    chk({tag, "_decode_state"}, state_o, 4'd1);
    chk({tag, "_decode_srcb"}, ALUSrcB, 2'b10);
    tick(); settle();
    chk({tag, "_exec_state"}, state_o, exs);
    chk({tag, "_exec_srca"}, ALUSrcA, 1'b0);
    chk({tag, "_exec_srcb"}, ALUSrcB, (exs == 4'd7) ? 2'b01 : 2'b00);
    chk({tag, "_exec_aluctrl"}, ALUCtrl, alu);
    chk({tag, "_exec_flagw"}, FlagW, fw);
    chk({tag, "_exec_regw"}, RegW, 1'b0);
    tick(); settle();
    chk({tag, "_aluwb_state"}, state_o, 4'd8);
    chk({tag, "_aluwb_regw"}, RegW, 1'b1);
    chk({tag, "_aluwb_nowrite"}, NoWrite, nw);
    chk({tag, "_aluwb_ressrc"}, ResultSrc, 2'b00);
    chk({tag, "_aluwb_flagw"}, FlagW, 2'b00);
    tick(); settle();
    chk({tag, "_back_fetch"}, state_o, 4'd0);
  endtask

  // Memory instruction from FETCH up to the first cycle of MEMRD/MEMWR.
  task automatic mem_front(input string tag, input logic [5:0] f, input logic [3:0] exs);
    Op = 2'b01; Funct = f; mem_ready = 1'b1;
    tick(); settle();
    chk({tag, "_decode_state"}, state_o, 4'd1);
    tick(); settle();
    chk({tag, "_memadr_state"}, state_o, 4'd2);
    chk({tag, "_memadr_srcb"}, ALUSrcB, 2'b01);
    chk({tag, "_memadr_srca"}, ALUSrcA, 1'b0);
    tick();
    chk({tag, "_enter_state"}, state_o, exs);
  endtask

  initial begin
    reset = 1'b0; Op = 2'b00; Funct = 6'b101001; mem_ready = 1'b1;
    #2;
    chk("rst_state", state_o, 4'd0);
    chk("rst_irwrite", IRWrite, 1'b0);
    chk("rst_nextpc", NextPC, 1'b0);
    chk("rst_srca", ALUSrcA, 1'b0);
    chk("rst_srcb", ALUSrcB, 2'b00);
    chk("rst_ressrc", ResultSrc, 2'b00);
    tick();
    chk("rst_hold_state", state_o, 4'd0);
    reset = 1'b1;
    settle();
    chk("fetch_state", state_o, 4'd0);
    chk("fetch_irwrite", IRWrite, 1'b1);
    chk("fetch_nextpc", NextPC, 1'b1);
    chk("fetch_srca", ALUSrcA, 1'b1);
    chk("fetch_srcb", ALUSrcB, 2'b10);
    chk("fetch_ressrc", ResultSrc, 2'b10);
    chk("fetch_adrsrc", AdrSrc, 1'b0);

    dp_instr("adds_imm", 6'b101001, 4'd7, 2'b00, 2'b11, 1'b0);
    dp_instr("cmp_reg", 6'b010101, 4'd6, 2'b01, 2'b11, 1'b1);
    dp_instr("ands_reg", 6'b000001, 4'd6, 2'b10, 2'b10, 1'b0);
    dp_instr("orr_imm", 6'b111000, 4'd7, 2'b11, 2'b00, 1'b0);
    dp_instr("sub_reg", 6'b000100, 4'd6, 2'b01, 2'b00, 1'b0);

    // LDR with three stall cycles in MEMRD
    mem_front("ldr", 6'b011001, 4'd3);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      mem_ready = (i == 3);
      settle();
      chk("ldr_memrd_state", state_o, 4'd3);
      chk("ldr_memrd_adrsrc", AdrSrc, 1'b1);
    end
    tick(); settle();
    chk("ldr_memwb_state", state_o, 4'd4);
    chk("ldr_memwb_ressrc", ResultSrc, 2'b01);
    chk("ldr_memwb_regw", RegW, 1'b1);
    tick(); settle();
    chk("ldr_back_fetch", state_o, 4'd0);

    // STR completing on the last cycle before expiry
    mem_front("str_ok", 6'b011000, 4'd5);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) tick();
      mem_ready = (i == 15);
      settle();
      chk("str_ok_state", state_o, 4'd5);
      chk("str_ok_memw", MemW, 1'b1);
      chk("str_ok_memerr", mem_err, 1'b0);
    end
    tick(); settle();
    chk("str_ok_fetch", state_o, 4'd0);
    chk("str_ok_memw_after", MemW, 1'b0);

    // STR with memory never ready: watchdog aborts on the 16th cycle
    mem_front("str_to", 6'b011000, 4'd5);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) tick();
      mem_ready = 1'b0;
      settle();
      chk("str_to_state", state_o, 4'd5);
      chk("str_to_memerr", mem_err, (i == 15));
    end
    tick(); settle();
    chk("str_to_fetch", state_o, 4'd0);
    chk("str_to_memw_after", MemW, 1'b0);
    chk("str_to_irwrite", IRWrite, 1'b0);

    // FETCH watchdog: expires in FETCH and stays there
    for (int i = 1; i < 16; i++) begin
      tick(); settle();
      chk("fetch_to_state", state_o, 4'd0);
      chk("fetch_to_memerr", mem_err, (i == 15));
    end
    tick(); settle();
    chk("fetch_rearm_memerr", mem_err, 1'b0);
    chk("fetch_rearm_state", state_o, 4'd0);
    mem_ready = 1'b1;
    settle();
    chk("fetch_ready_irwrite", IRWrite, 1'b1);

    // Illegal opcode
    Op = 2'b11; Funct = 6'b000000;
    tick(); settle();
    chk("ill_decode_state", state_o, 4'd1);
    chk("ill_pulse", illegal_op, 1'b1);
    tick(); settle();
    chk("ill_fetch_state", state_o, 4'd0);
    chk("ill_pulse_end", illegal_op, 1'b0);

    // Branch
    Op = 2'b10;
    tick(); tick(); settle();
    chk("br_state", state_o, 4'd9);
    chk("br_pcs", PCS, 1'b1);
    chk("br_srcb", ALUSrcB, 2'b01);
    chk("br_regw", RegW, 1'b0);
    tick(); settle();
    chk("br_fetch", state_o, 4'd0);
    chk("br_pcs_end", PCS, 1'b0);

    // Asynchronous reset in the middle of a store
    mem_front("str_rst", 6'b011000, 4'd5);
    mem_ready = 1'b0;
    settle();
    chk("str_rst_memw_before", MemW, 1'b1);
    reset = 1'b0;
    #1;
    chk("str_rst_memw_async", MemW, 1'b0);
    chk("str_rst_state_async", state_o, 4'd0);
    chk("str_rst_adrsrc_async", AdrSrc, 1'b0);
    mem_ready = 1'b1;
    tick(); settle();
    chk("str_rst_hold_irwrite", IRWrite, 1'b0);
    chk("str_rst_hold_memw", MemW, 1'b0);
    reset = 1'b1;
    settle();
    chk("str_rst_release_state", state_o, 4'd0);
    chk("str_rst_release_irwrite", IRWrite, 1'b1);
    tick(); settle();
    chk("str_rst_release_decode", state_o, 4'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
